btn_repeat: RTL and testbench
=============================

Name: btn_repeat

Overview:
- Consumes the debounced level of one DE0 push-button and produces single-cycle event strobes for the pulse-generator control logic.
- Strobes: press, release, and "step". A step fires once on press, then auto-repeats while the button is held: first after a hold delay, then at a fixed period.
- Sits directly downstream of the per-button debouncer. One instance per button, all on the system clock.

Parameters:
- P_ACTIVE_LOW, 1, 1 = button pressed when btn==0 (DE0 keys); 0 = pressed when btn==1.
- P_HOLD_DELAY, 8, cycles from the initial step to the first repeat step; legal range >=1.
- P_REPEAT_PERIOD, 4, cycles between consecutive repeat steps; legal range >=1.
- P_REPEAT_EN, 1, 0 = disable auto-repeat: step fires on press only.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  debounced button level, synchronous to clk.
- press  output  1  one-cycle strobe on the press edge.
- release  output  1  one-cycle strobe on the release edge.
- step  output  1  one-cycle strobe on the press edge and on each auto-repeat.
- held  output  1  high while the FSM is in DELAY or REPEAT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, counter=0.
  - press, release, step and held all 0.
- Definition: pressed = (btn != P_ACTIVE_LOW). All outputs are registered. Every event is visible the cycle after the clock edge that sampled btn.
- Counter:
  - Width = clogb2(max(P_HOLD_DELAY, P_REPEAT_PERIOD)).
  - Cleared on every state entry; increments once per cycle in DELAY and REPEAT.
- IDLE:
  - When pressed is sampled: press=1, step=1 for one cycle, held=1, go to DELAY.
  - Otherwise all strobes stay 0.
- DELAY:
  - Not pressed: release=1 for one cycle, held=0, go to IDLE. No step is issued.
  - Else, if counter==P_HOLD_DELAY-1 and P_REPEAT_EN: step=1, go to REPEAT, counter=0.
  - Else, if P_REPEAT_EN=0: remain in DELAY indefinitely. The counter saturates and does not wrap.
- REPEAT:
  - Not pressed: release=1, go to IDLE.
  - Else, if counter==P_REPEAT_PERIOD-1: step=1, counter=0, stay in REPEAT.
- Simultaneous events:
  - Release sampled in the same cycle as counter expiry: release wins. release=1, step=0.
- Step timing:
  - Initial step at cycle T.
  - First repeat at T+P_HOLD_DELAY.
  - Subsequent repeats every P_REPEAT_PERIOD cycles.
- Strobe rules:
  - press and release are never high in the same cycle.
  - Strobes are always exactly one cycle wide.
- Input toggles every cycle: each transition yields an alternating press/release strobe. The debouncer upstream prevents this in practice, but the FSM still handles it.
- Reset mid-operation: outputs drop to 0 asynchronously. No release strobe is emitted on reset or on reset exit.
- A button held through reset exit: a press/step pair fires on the first clock after reset deasserts.
- Out-of-range parameters (P_HOLD_DELAY or P_REPEAT_PERIOD = 0): the synthesis-time check fails. No runtime behaviour is defined.

Decomposition:
- Shared include (pulse_gen_defs.vh):
  - state encodings: IDLE=0, DELAY=1, REPEAT=2;
  - the clogb2 function, shared with the debouncer.
- Sub-module: none. FSM, counter and output registers live in one module.
- Top level pairs one debounce instance with one btn_repeat instance per key.

Test Plan:
- Reset with btn=1 (active-low, released), hold 20 cycles -> press, release, step and held all 0 throughout.
- btn 1->0 at cycle 10, back to 1 at cycle 14 (P_HOLD_DELAY=8) -> press and step high at cycle 11 only; release high at cycle 15; no further steps.
- btn held 0 from cycle 10 for 30 cycles (delay 8, period 4) -> steps at 11, 19, 23, 27, 31, 35, 39; held=1 from 11 until release.
- Release timed to coincide with counter expiry (btn->1 sampled at the edge that would produce the step at 23) -> release=1 at 23, step=0 at 23, state IDLE.
- rst_n pulsed low at cycle 20 during REPEAT -> held drops immediately with no release strobe. With btn still 0 after reset exit, press/step fires one cycle after the first post-reset edge.
- P_REPEAT_EN=0, btn held 0 for 100 cycles -> exactly one step and one press; one release when btn returns to 1.

Source files
------------

// File: rtl/btn_repeat_pkg.sv
// Shared state encodings and sizing helpers for the push-button event logic.
package btn_repeat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    function automatic int clogb2(input int n);
        int v;
        int r;
        v = n - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter must hold the larger of the two terminal values; never narrower than 1 bit.
    function automatic int cnt_width(input int hold_delay, input int repeat_period);
        int m;
        int w;
        m = (hold_delay > repeat_period) ? hold_delay : repeat_period;
        w = clogb2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Turns a debounced button level into press/release/step strobes with hold-to-repeat.
module btn_repeat
    import btn_repeat_pkg::*;
#(
    parameter bit P_ACTIVE_LOW    = 1'b1,
    parameter int P_HOLD_DELAY    = 8,
    parameter int P_REPEAT_PERIOD = 4,
    parameter bit P_REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press,
    // 'release' is a reserved word in SystemVerilog, so the release strobe is rel.
    output logic rel,
    output logic step,
    output logic held
);

    localparam int CNT_W = cnt_width(P_HOLD_DELAY, P_REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(P_HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(P_REPEAT_PERIOD - 1);

    if (P_HOLD_DELAY < 1 || P_REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_repeat: P_HOLD_DELAY and P_REPEAT_PERIOD must be >= 1");
    end

    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pressed;

    assign pressed = (btn != P_ACTIVE_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
            step  <= 1'b0;
            held  <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            step  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pressed) begin
                        press <= 1'b1;
                        step  <= 1'b1;
                        held  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    // Release is tested first so it wins over a coincident expiry.
                    if (!pressed) begin
                        rel   <= 1'b1;
                        held  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (P_REPEAT_EN && cnt == HOLD_LAST) begin
                        step  <= 1'b1;
                        cnt   <= '0;
                        state <= ST_REPEAT;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!pressed) begin
                        rel   <= 1'b1;
                        held  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (cnt == PER_LAST) begin
                        step <= 1'b1;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    held  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_repeat.sv
// Directed scoreboard bench for btn_repeat: repeat-enabled and repeat-disabled instances.
module tb_btn_repeat;

    logic clk;
    logic rst_n;
    logic btn;
    logic press1, rel1, step1, held1;
    logic press2, rel2, step2, held2;
    logic rst_lvl;

    int n_vec;
    int n_err;

    // Expected {press, rel, step, held} for the outputs after the next rising edge.
    logic [3:0] q1[$];
    logic [3:0] q2[$];

    btn_repeat #(
        .P_ACTIVE_LOW(1'b1), .P_HOLD_DELAY(8), .P_REPEAT_PERIOD(4), .P_REPEAT_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .press(press1), .rel(rel1), .step(step1), .held(held1)
    );

    btn_repeat #(
        .P_ACTIVE_LOW(1'b1), .P_HOLD_DELAY(8), .P_REPEAT_PERIOD(4), .P_REPEAT_EN(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .press(press2), .rel(rel2), .step(step2), .held(held2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: checks each instance whenever an expectation is pending for that edge.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                n_vec++;
                if ({press1, rel1, step1, held1} !== e) begin
                    n_err++;
                    $display("FAIL rep_on t=%0t got p/r/s/h=%b expected %b", $time,
                             {press1, rel1, step1, held1}, e);
                end
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                n_vec++;
                if ({press2, rel2, step2, held2} !== e) begin
                    n_err++;
                    $display("FAIL rep_off t=%0t got p/r/s/h=%b expected %b", $time,
                             {press2, rel2, step2, held2}, e);
                end
            end
        end
    end

    task automatic cyc(input logic b, input logic [3:0] e1);
        @(negedge clk);
        rst_n = rst_lvl;
        btn   = b;
        q1.push_back(e1);
    endtask

    task automatic cyc2(input logic b, input logic [3:0] e1, input logic [3:0] e2);
        @(negedge clk);
        rst_n = rst_lvl;
        btn   = b;
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    // Hold delay 8, period 4: steps at hold index 0, 8, 12, 16, ...
    function automatic logic [3:0] hold_exp(input int k);
        if (k == 0) return 4'b1011;
        if (k >= 8 && (k - 8) % 4 == 0) return 4'b0011;
        return 4'b0001;
    endfunction

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got p/r/s/h=%b expected %b", name, got, exp);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        rst_lvl = 1'b0;
        btn     = 1'b1;

        // Reset held for 20 cycles with button released: all outputs low.
        for (int i = 0; i < 20; i++) cyc2(1'b1, 4'b0000, 4'b0000);

        // Short press: 4 sampled edges low, then release.
        rst_lvl = 1'b1;
        for (int i = 0; i < 9; i++) cyc2(1'b1, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b1011);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0001);
        cyc(1'b1, 4'b0100);
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'b0000);

        // Long hold: 30 edges pressed.
        for (int k = 0; k < 30; k++) cyc(1'b0, hold_exp(k));
        cyc(1'b1, 4'b0100);
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b0000);

        // Release lands on the edge that would issue the second repeat step.
        for (int k = 0; k < 12; k++) cyc(1'b0, hold_exp(k));
        cyc(1'b1, 4'b0100);
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'b0000);

        // Asynchronous reset in REPEAT, button still held through reset exit.
        for (int k = 0; k < 10; k++) cyc(1'b0, hold_exp(k));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_now("async_rst_on", {press1, rel1, step1, held1}, 4'b0000);
        check_now("async_rst_off", {press2, rel2, step2, held2}, 4'b0000);
        rst_lvl = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000);
        rst_lvl = 1'b1;
        cyc(1'b0, 4'b1011);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0001);
        cyc(1'b1, 4'b0100);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0000);

        // Input toggling every cycle.
        cyc(1'b0, 4'b1011);
        cyc(1'b1, 4'b0100);
        cyc(1'b0, 4'b1011);
        cyc(1'b1, 4'b0100);
        cyc(1'b1, 4'b0000);

        // 100-cycle hold on both instances: repeat-disabled one steps exactly once.
        for (int k = 0; k < 100; k++)
            cyc2(1'b0, hold_exp(k), (k == 0) ? 4'b1011 : 4'b0001);
        cyc2(1'b1, 4'b0100, 4'b0100);
        for (int i = 0; i < 4; i++) cyc2(1'b1, 4'b0000, 4'b0000);

        // Drain: every pushed expectation must have been consumed.
        repeat (4) @(posedge clk);
        #3;
        if (q1.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d expected 0", q1.size() + q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
